// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg: shared widths, opcode encodings and idle ("free") constants
// for the integer execute stage and its reservation-station neighbours.
package alu_exec_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int TAG_W  = 6;
  localparam int NAME_W = 5;
  localparam int OP_W   = 6;

  // Values driven on the result buses whenever no valid result is present.
  localparam logic [TAG_W-1:0]  TAG_FREE  = '1;
  localparam logic [DATA_W-1:0] DATA_FREE = '0;
  localparam logic [NAME_W-1:0] NAME_FREE = '0;
  localparam logic [ADDR_W-1:0] ADDR_FREE = '0;

  // Immediate forms share behaviour with their register forms because the
  // dispatcher has already placed the immediate on operandT.
  // Encodings above OP_BGEU are unused and are executed as idle.
  typedef enum logic [OP_W-1:0] {
    OP_NOP   = 6'd0,
    OP_ADD   = 6'd1,  OP_ADDI  = 6'd2,  OP_SUB   = 6'd3,
    OP_AND   = 6'd4,  OP_ANDI  = 6'd5,  OP_OR    = 6'd6,
    OP_ORI   = 6'd7,  OP_XOR   = 6'd8,  OP_XORI  = 6'd9,
    OP_SLT   = 6'd10, OP_SLTI  = 6'd11, OP_SLTU  = 6'd12,
    OP_SLTIU = 6'd13, OP_SLL   = 6'd14, OP_SLLI  = 6'd15,
    OP_SRL   = 6'd16, OP_SRLI  = 6'd17, OP_SRA   = 6'd18,
    OP_SRAI  = 6'd19, OP_LUI   = 6'd20, OP_AUIPC = 6'd21,
    OP_JAL   = 6'd22, OP_JALR  = 6'd23, OP_BEQ   = 6'd24,
    OP_BNE   = 6'd25, OP_BLT   = 6'd26, OP_BGE   = 6'd27,
    OP_BLTU  = 6'd28, OP_BGEU  = 6'd29
  } op_e;

endpackage

// File: rtl/alu_exec_if.sv
// alu_exec_if: issue bus from the ALU reservation station into the execute
// stage, and the result buses it drives (CDB, regfile write, fetch redirect).
//   master : reservation-station side (drives issue + clr, observes results)
//   slave  : execute stage side
// Handshake: ALUworkEn is a valid with no ready; the stage accepts an op on
// every rising edge where it is high. Each output valid (enALUwrt, enRegWrt,
// jumpEn) is a single-cycle pulse qualifying its own payload for that cycle
// only; payloads hold the free constants whenever their valid is low.
interface alu_exec_if;
  import alu_exec_pkg::*;

  logic              clr;
  logic              ALUworkEn;
  logic [DATA_W-1:0] operandO;
  logic [DATA_W-1:0] operandT;
  logic [TAG_W-1:0]  wrtTag;
  logic [NAME_W-1:0] wrtName;
  logic [OP_W-1:0]   opCode;
  logic [ADDR_W-1:0] instAddr;

  logic              enALUwrt;
  logic [TAG_W-1:0]  ALUtag;
  logic [DATA_W-1:0] ALUdata;
  logic              enRegWrt;
  logic [NAME_W-1:0] regName;
  logic [DATA_W-1:0] regData;
  logic              jumpEn;
  logic [ADDR_W-1:0] jumpAddr;

  modport master (
    output clr, ALUworkEn, operandO, operandT, wrtTag, wrtName, opCode, instAddr,
    input  enALUwrt, ALUtag, ALUdata, enRegWrt, regName, regData, jumpEn, jumpAddr
  );

  modport slave (
    input  clr, ALUworkEn, operandO, operandT, wrtTag, wrtName, opCode, instAddr,
    output enALUwrt, ALUtag, ALUdata, enRegWrt, regName, regData, jumpEn, jumpAddr
  );
endinterface

// File: rtl/alu_exec_core.sv
// alu_core: purely combinational RV32I integer/branch datapath.
// Ports:
//   op_i, a_i (rs1), b_i (rs2/imm), pc_i (PC, or branch target for Bxx)
//   result_o    data result for non-branch ops
//   known_o     op is a real operation (not NOP / unused encoding)
//   is_branch_o op is a conditional branch (produces no data result)
//   taken_o     redirect required (taken branch, or any JALR)
//   target_o    redirect address
module alu_core
  import alu_exec_pkg::*;
(
  input  logic [OP_W-1:0]   op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic [DATA_W-1:0] result_o,
  output logic              known_o,
  output logic              is_branch_o,
  output logic              taken_o,
  output logic [ADDR_W-1:0] target_o
);

  logic [DATA_W-1:0] sum;
  logic [4:0]        shamt;
  logic              lt_s;
  logic              lt_u;

  assign sum   = a_i + b_i;
  assign shamt = b_i[4:0];
  assign lt_s  = $signed(a_i) < $signed(b_i);
  assign lt_u  = a_i < b_i;

  always_comb begin
    result_o    = '0;
    known_o     = 1'b1;
    is_branch_o = 1'b0;
    taken_o     = 1'b0;
    target_o    = pc_i;
    case (op_i)
      OP_ADD,  OP_ADDI:  result_o = sum;
      OP_SUB:            result_o = a_i - b_i;
      OP_AND,  OP_ANDI:  result_o = a_i & b_i;
      OP_OR,   OP_ORI:   result_o = a_i | b_i;
      OP_XOR,  OP_XORI:  result_o = a_i ^ b_i;
      OP_SLT,  OP_SLTI:  result_o = {31'd0, lt_s};
      OP_SLTU, OP_SLTIU: result_o = {31'd0, lt_u};
      OP_SLL,  OP_SLLI:  result_o = a_i << shamt;
      OP_SRL,  OP_SRLI:  result_o = a_i >> shamt;
      OP_SRA,  OP_SRAI:  result_o = $signed(a_i) >>> shamt;
      OP_LUI:            result_o = b_i;
      OP_AUIPC:          result_o = pc_i + b_i;
      OP_JAL:            result_o = pc_i + 32'd4;
      OP_JALR: begin
        result_o = pc_i + 32'd4;
        taken_o  = 1'b1;
        // Target LSB is forced to zero, as RV32I requires for JALR.
        target_o = {sum[DATA_W-1:1], 1'b0};
      end
      // Fetch predicted not-taken, so only a taken branch redirects, and it
      // redirects to the precomputed target carried on pc_i.
      OP_BEQ:  begin is_branch_o = 1'b1; taken_o = (a_i == b_i); end
      OP_BNE:  begin is_branch_o = 1'b1; taken_o = (a_i != b_i); end
      OP_BLT:  begin is_branch_o = 1'b1; taken_o = lt_s;         end
      OP_BGE:  begin is_branch_o = 1'b1; taken_o = ~lt_s;        end
      OP_BLTU: begin is_branch_o = 1'b1; taken_o = lt_u;         end
      OP_BGEU: begin is_branch_o = 1'b1; taken_o = ~lt_u;        end
      default: known_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_exec.sv
// alu_exec: one-cycle, fully pipelined integer execute stage.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  alu_exec_if.slave: issue from the RS (incl. clr flush) and the
//        registered CDB / regfile-write / fetch-redirect outputs
// The datapath lives in alu_core; this module only qualifies its outputs and
// registers them, so every issued op appears on the buses one cycle later.
module alu_exec
  import alu_exec_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  alu_exec_if.slave  bus
);

  logic [DATA_W-1:0] core_result;
  logic              core_known;
  logic              core_is_branch;
  logic              core_taken;
  logic [ADDR_W-1:0] core_target;

  alu_core u_core (
    .op_i        (bus.opCode),
    .a_i         (bus.operandO),
    .b_i         (bus.operandT),
    .pc_i        (bus.instAddr),
    .result_o    (core_result),
    .known_o     (core_known),
    .is_branch_o (core_is_branch),
    .taken_o     (core_taken),
    .target_o    (core_target)
  );

  logic              live;
  logic              cdb_en_d,   cdb_en_q;
  logic [TAG_W-1:0]  cdb_tag_d,  cdb_tag_q;
  logic [DATA_W-1:0] cdb_data_d, cdb_data_q;
  logic              reg_en_d,   reg_en_q;
  logic [NAME_W-1:0] reg_name_d, reg_name_q;
  logic [DATA_W-1:0] reg_data_d, reg_data_q;
  logic              jmp_en_d,   jmp_en_q;
  logic [ADDR_W-1:0] jmp_addr_d, jmp_addr_q;

  // A flush wins over an issue in the same cycle; NOP/unused ops are idle.
  assign live = bus.ALUworkEn & ~bus.clr & core_known;

  always_comb begin
    // The CDB fires even for writes to x0 so waiting RS entries still wake.
    cdb_en_d   = live & ~core_is_branch;
    cdb_tag_d  = cdb_en_d ? bus.wrtTag : TAG_FREE;
    cdb_data_d = cdb_en_d ? core_result : DATA_FREE;
    reg_en_d   = cdb_en_d & (bus.wrtName != '0);
    reg_name_d = reg_en_d ? bus.wrtName : NAME_FREE;
    reg_data_d = reg_en_d ? core_result : DATA_FREE;
    jmp_en_d   = live & core_taken;
    jmp_addr_d = jmp_en_d ? core_target : ADDR_FREE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_en_q   <= 1'b0;
      cdb_tag_q  <= TAG_FREE;
      cdb_data_q <= DATA_FREE;
      reg_en_q   <= 1'b0;
      reg_name_q <= NAME_FREE;
      reg_data_q <= DATA_FREE;
      jmp_en_q   <= 1'b0;
      jmp_addr_q <= ADDR_FREE;
    end else begin
      cdb_en_q   <= cdb_en_d;
      cdb_tag_q  <= cdb_tag_d;
      cdb_data_q <= cdb_data_d;
      reg_en_q   <= reg_en_d;
      reg_name_q <= reg_name_d;
      reg_data_q <= reg_data_d;
      jmp_en_q   <= jmp_en_d;
      jmp_addr_q <= jmp_addr_d;
    end
  end

  assign bus.enALUwrt = cdb_en_q;
  assign bus.ALUtag   = cdb_tag_q;
  assign bus.ALUdata  = cdb_data_q;
  assign bus.enRegWrt = reg_en_q;
  assign bus.regName  = reg_name_q;
  assign bus.regData  = reg_data_q;
  assign bus.jumpEn   = jmp_en_q;
  assign bus.jumpAddr = jmp_addr_q;

endmodule

// File: tb/tb_alu_exec.sv
module tb_alu_exec;
  import alu_exec_pkg::*;

  localparam int OUT_W = 1 + TAG_W + DATA_W + 1 + NAME_W + DATA_W + 1 + ADDR_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_exec_if bus ();

  alu_exec u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard ----------------
  logic [OUT_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [OUT_W-1:0] pk(
    input logic ea, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d,
    input logic er, input logic [NAME_W-1:0] n, input logic [DATA_W-1:0] rd,
    input logic je, input logic [ADDR_W-1:0] ja);
    return {ea, t, d, er, n, rd, je, ja};
  endfunction

  function automatic logic [OUT_W-1:0] idle_v();
    return pk(1'b0, TAG_FREE, DATA_FREE, 1'b0, NAME_FREE, DATA_FREE, 1'b0, ADDR_FREE);
  endfunction

  // Reference model for the randomized section.
  function automatic logic [OUT_W-1:0] model(
    input logic en, input logic cl, input logic [OP_W-1:0] op,
    input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
    input logic [TAG_W-1:0] tag, input logic [NAME_W-1:0] name);
    logic [31:0] r, ab, ja;
    logic        res, jmp;
    r = 32'd0; res = 1'b0; jmp = 1'b0; ja = pc; ab = a + b;
    if (en && !cl) begin
      res = 1'b1;
      case (op)
        OP_ADD, OP_ADDI:   r = ab;
        OP_SUB:            r = a + (~b + 32'd1);
        OP_AND, OP_ANDI:   r = a & b;
        OP_OR, OP_ORI:     r = a | b;
        OP_XOR, OP_XORI:   r = a ^ b;
        OP_SLT, OP_SLTI:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        OP_SLTU, OP_SLTIU: r = (a < b) ? 32'd1 : 32'd0;
        OP_SLL, OP_SLLI:   r = a << b[4:0];
        OP_SRL, OP_SRLI:   r = a >> b[4:0];
        OP_SRA, OP_SRAI:   r = 32'($signed(a) >>> b[4:0]);
        OP_LUI:            r = b;
        OP_AUIPC:          r = pc + b;
        OP_JAL:            r = pc + 32'd4;
        OP_JALR: begin r = pc + 32'd4; jmp = 1'b1; ja = ab & 32'hFFFF_FFFE; end
        OP_BEQ:  begin res = 1'b0; jmp = (a == b); end
        OP_BNE:  begin res = 1'b0; jmp = (a != b); end
        OP_BLT:  begin res = 1'b0; jmp = ($signed(a) < $signed(b)); end
        OP_BGE:  begin res = 1'b0; jmp = ($signed(a) >= $signed(b)); end
        OP_BLTU: begin res = 1'b0; jmp = (a < b); end
        OP_BGEU: begin res = 1'b0; jmp = (a >= b); end
        default: res = 1'b0;
      endcase
    end
    return pk(res, res ? tag : TAG_FREE, res ? r : DATA_FREE,
              res && (name != 0), (res && name != 0) ? name : NAME_FREE,
              (res && name != 0) ? r : DATA_FREE,
              jmp, jmp ? ja : ADDR_FREE);
  endfunction

  task automatic check(input string tag);
    logic [OUT_W-1:0] obs, exp;
    obs = {bus.enALUwrt, bus.ALUtag, bus.ALUdata, bus.enRegWrt,
           bus.regName, bus.regData, bus.jumpEn, bus.jumpAddr};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: no expected entry, observed %h", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic en, input logic cl, input logic [OP_W-1:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                       input logic [TAG_W-1:0] tag, input logic [NAME_W-1:0] name);
    bus.ALUworkEn = en;
    bus.clr       = cl;
    bus.opCode    = op;
    bus.operandO  = a;
    bus.operandT  = b;
    bus.instAddr  = pc;
    bus.wrtTag    = tag;
    bus.wrtName   = name;
  endtask

  // Issue one op at the falling edge, then check its result just after the
  // next rising edge.
  task automatic step(input logic en, input logic cl, input logic [OP_W-1:0] op,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                      input logic [TAG_W-1:0] tag, input logic [NAME_W-1:0] name,
                      input logic [OUT_W-1:0] exp, input string t);
    @(negedge clk);
    drive(en, cl, op, a, b, pc, tag, name);
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    check(t);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    drive(1'b0, 1'b0, OP_NOP, 32'd0, 32'd0, 32'd0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(idle_v());
    check("reset_idle");
    @(negedge clk);
    rst = 1'b0;

    // ADD 7 + (-3), tag 5, x3
    step(1, 0, OP_ADD, 32'd7, 32'hFFFF_FFFD, 32'h0, 6'd5, 5'd3,
         pk(1, 6'd5, 32'd4, 1, 5'd3, 32'd4, 0, ADDR_FREE), "add_basic");
    // back-to-back SRA and SLTU
    step(1, 0, OP_SRA, 32'h8000_0000, 32'd4, 32'h0, 6'd7, 5'd4,
         pk(1, 6'd7, 32'hF800_0000, 1, 5'd4, 32'hF800_0000, 0, ADDR_FREE), "sra_neg");
    step(1, 0, OP_SLTU, 32'd1, 32'hFFFF_FFFF, 32'h0, 6'd8, 5'd5,
         pk(1, 6'd8, 32'd1, 1, 5'd5, 32'd1, 0, ADDR_FREE), "sltu_b2b");
    // branches: -1 vs 1
    step(1, 0, OP_BLT, 32'hFFFF_FFFF, 32'd1, 32'h100, 6'd9, 5'd0,
         pk(0, TAG_FREE, DATA_FREE, 0, NAME_FREE, DATA_FREE, 1, 32'h100), "blt_taken");
    step(1, 0, OP_BGE, 32'hFFFF_FFFF, 32'd1, 32'h100, 6'd9, 5'd0,
         idle_v(), "bge_not_taken");
    step(1, 0, OP_BGEU, 32'hFFFF_FFFF, 32'd1, 32'h100, 6'd9, 5'd0,
         pk(0, TAG_FREE, DATA_FREE, 0, NAME_FREE, DATA_FREE, 1, 32'h100), "bgeu_taken");
    step(1, 0, OP_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h100, 6'd9, 5'd0,
         idle_v(), "bltu_not_taken");
    // JALR
    step(1, 0, OP_JALR, 32'h203, 32'd4, 32'h40, 6'd10, 5'd1,
         pk(1, 6'd10, 32'h44, 1, 5'd1, 32'h44, 1, 32'h206), "jalr");
    // flush beats issue
    step(1, 1, OP_ADD, 32'd1, 32'd2, 32'h0, 6'd11, 5'd2, idle_v(), "clr_kill");
    // write to x0 still broadcasts on the CDB
    step(1, 0, OP_ADD, 32'd10, 32'd20, 32'h0, 6'd12, 5'd0,
         pk(1, 6'd12, 32'd30, 0, NAME_FREE, DATA_FREE, 0, ADDR_FREE), "add_x0");
    // NOP and an unused encoding with valid high are idle
    step(1, 0, OP_NOP, 32'd1, 32'd1, 32'h0, 6'd13, 5'd6, idle_v(), "nop_idle");
    step(1, 0, 6'd45, 32'd1, 32'd1, 32'h0, 6'd13, 5'd6, idle_v(), "unknown_idle");
    step(0, 0, OP_ADD, 32'd1, 32'd1, 32'h0, 6'd13, 5'd6, idle_v(), "no_issue");
    // LUI / AUIPC / JAL
    step(1, 0, OP_LUI, 32'd0, 32'h1234_5000, 32'h0, 6'd14, 5'd7,
         pk(1, 6'd14, 32'h1234_5000, 1, 5'd7, 32'h1234_5000, 0, ADDR_FREE), "lui");
    step(1, 0, OP_AUIPC, 32'd0, 32'h0000_1000, 32'h80, 6'd15, 5'd8,
         pk(1, 6'd15, 32'h1080, 1, 5'd8, 32'h1080, 0, ADDR_FREE), "auipc");
    step(1, 0, OP_JAL, 32'd0, 32'd0, 32'h200, 6'd16, 5'd9,
         pk(1, 6'd16, 32'h204, 1, 5'd9, 32'h204, 0, ADDR_FREE), "jal");

    // async reset between edges discards the in-flight result at once
    step(1, 0, OP_ADD, 32'd3, 32'd4, 32'h0, 6'd17, 5'd10,
         pk(1, 6'd17, 32'd7, 1, 5'd10, 32'd7, 0, ADDR_FREE), "pre_rst_add");
    #1 rst = 1'b1;
    #1;
    exp_q.push_back(idle_v());
    check("async_rst_idle");
    @(negedge clk);
    rst = 1'b0;
    step(1, 0, OP_SUB, 32'd3, 32'd5, 32'h0, 6'd18, 5'd11,
         pk(1, 6'd18, 32'hFFFF_FFFE, 1, 5'd11, 32'hFFFF_FFFE, 0, ADDR_FREE), "post_rst_sub");

    // randomized back-to-back traffic against the model
    for (int i = 0; i < 60; i++) begin
      logic              en, cl;
      logic [OP_W-1:0]   op;
      logic [31:0]       a, b, pc;
      logic [TAG_W-1:0]  tg;
      logic [NAME_W-1:0] nm;
      en = ($urandom_range(0, 9) != 0);
      cl = ($urandom_range(0, 9) == 0);
      op = 6'($urandom_range(0, 33));
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      pc = {$urandom_range(0, 65535), 2'b00};
      tg = 6'($urandom_range(0, 62));
      nm = 5'($urandom_range(0, 31));
      step(en, cl, op, a, b, pc, tg, nm, model(en, cl, op, a, b, pc, tg, nm), "random");
    end

    @(negedge clk);
    drive(1'b0, 1'b0, OP_NOP, 32'd0, 32'd0, 32'd0, '0, '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
